// File: rtl/hilo_unit.sv
// HI/LO architectural register pair: sequences div/mult busy windows, captures
// their results, latches divide-by-zero and serves mfhi/mflo/mthi/mtlo.
module hilo_unit #(
    parameter int N_BITS      = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              divCtrl,
    input  logic              multCtrl,
    input  logic              divZero,
    input  logic [N_BITS-1:0] divHi,
    input  logic [N_BITS-1:0] divLo,
    input  logic [N_BITS-1:0] multHi,
    input  logic [N_BITS-1:0] multLo,
    input  logic              mfhi,
    input  logic              mflo,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [N_BITS-1:0] wrData,
    output logic [N_BITS-1:0] hi,
    output logic [N_BITS-1:0] lo,
    output logic [N_BITS-1:0] readData,
    output logic              busy,
    output logic              stall,
    output logic              divZeroExc
);

    typedef enum logic [1:0] {IDLE, DIV_BUSY, MULT_BUSY} state_t;

    localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_BITS-1:0] hi_nxt, lo_nxt;
    logic              exc_nxt;

    assign busy     = (state != IDLE);
    assign stall    = busy & (mfhi | mflo | mthi | mtlo | divCtrl | multCtrl);
    assign readData = mfhi ? hi : lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            divZeroExc <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hi         <= hi_nxt;
            lo         <= lo_nxt;
            divZeroExc <= exc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        exc_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // Moves land even when a start is issued in the same cycle.
                if (mthi) hi_nxt = wrData;
                if (mtlo) lo_nxt = wrData;
                if (divCtrl) begin
                    if (divZero) begin
                        exc_nxt = 1'b1;
                    end else begin
                        state_nxt = DIV_BUSY;
                        cnt_nxt   = DIV_LOAD;
                    end
                end else if (multCtrl) begin
                    state_nxt = MULT_BUSY;
                    cnt_nxt   = MULT_LOAD;
                end
            end
            DIV_BUSY: begin
                // A zero divisor aborts even on what would be the capture edge.
                if (divZero) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    exc_nxt   = 1'b1;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    hi_nxt    = divHi;
                    lo_nxt    = divLo;
                    state_nxt = IDLE;
                end
            end
            MULT_BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    hi_nxt    = multHi;
                    lo_nxt    = multLo;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: reset, div/mult latency, stall, divide-by-zero,
// start priority, moves and async reset mid-operation.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        divCtrl, multCtrl, divZero;
    logic [31:0] divHi, divLo, multHi, multLo, wrData;
    logic        mfhi, mflo, mthi, mtlo;
    logic [31:0] hi, lo, readData;
    logic        busy, stall, divZeroExc;

    int total = 0;
    int bad   = 0;

    hilo_unit #(.N_BITS(32), .DIV_CYCLES(32), .MULT_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .divCtrl(divCtrl), .multCtrl(multCtrl),
        .divZero(divZero), .divHi(divHi), .divLo(divLo), .multHi(multHi),
        .multLo(multLo), .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
        .wrData(wrData), .hi(hi), .lo(lo), .readData(readData), .busy(busy),
        .stall(stall), .divZeroExc(divZeroExc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        divCtrl = 0; multCtrl = 0; divZero = 0;
        divHi = 0; divLo = 0; multHi = 0; multLo = 0; wrData = 0;
        mfhi = 0; mflo = 0; mthi = 0; mtlo = 0;
        tick(); tick();
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (divZeroExc !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b exp=0", divZeroExc); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_div_stall();
        divHi = 32'hFFFF_FFFF; divLo = 32'hFFFF_FFFC; divCtrl = 1;
        tick();
        divCtrl = 0; mflo = 1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL div_start_busy got=%b exp=1", busy); end
        for (int k = 1; k <= 32; k++) begin
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL div_stall cyc=%0d got=%b exp=1", k, stall); end
            if (k == 32) begin
                total++; if (lo !== 32'h0) begin bad++; $display("FAIL div_early_capture got=%h exp=0", lo); end
            end
            tick();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL div_done_busy got=%b exp=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL div_done_stall got=%b exp=0", stall); end
        total++; if (readData !== 32'hFFFF_FFFC) begin bad++; $display("FAIL div_readData got=%h exp=fffffffc", readData); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        mflo = 0;
    endtask

    task automatic test_div_zero();
        mthi = 1; wrData = 32'd5; tick(); mthi = 0;
        mtlo = 1; wrData = 32'd7; tick(); mtlo = 0;
        divCtrl = 1; divZero = 1; divHi = 32'h11; divLo = 32'h22;
        tick();
        divCtrl = 0; divZero = 0;
        total++; if (divZeroExc !== 1'b1) begin bad++; $display("FAIL dz_exc got=%b exp=1", divZeroExc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy got=%b exp=0", busy); end
        total++; if (hi !== 32'd5) begin bad++; $display("FAIL dz_hi got=%h exp=5", hi); end
        total++; if (lo !== 32'd7) begin bad++; $display("FAIL dz_lo got=%h exp=7", lo); end
        tick();
        total++; if (divZeroExc !== 1'b0) begin bad++; $display("FAIL dz_exc_pulse got=%b exp=0", divZeroExc); end
    endtask

    task automatic test_div_abort();
        divCtrl = 1; tick(); divCtrl = 0;
        repeat (5) tick();
        divZero = 1; tick(); divZero = 0;
        total++; if (divZeroExc !== 1'b1) begin bad++; $display("FAIL abort_exc got=%b exp=1", divZeroExc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tick();
        total++; if (divZeroExc !== 1'b0) begin bad++; $display("FAIL abort_exc_pulse got=%b exp=0", divZeroExc); end
        repeat (35) tick();
        total++; if (hi !== 32'd5) begin bad++; $display("FAIL abort_hi got=%h exp=5", hi); end
    endtask

    task automatic test_priority();
        divHi = 32'd1; divLo = 32'd2; multHi = 32'hAA; multLo = 32'hBB;
        divCtrl = 1; multCtrl = 1;
        tick();
        divCtrl = 0; multCtrl = 1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL prio_busy got=%b exp=1", busy); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL prio_mult_stall got=%b exp=1", stall); end
        repeat (3) tick();
        multCtrl = 0;
        repeat (27) tick();
        total++; if (hi !== 32'd5) begin bad++; $display("FAIL prio_early got=%h exp=5", hi); end
        tick(); tick();
        total++; if (hi !== 32'd1) begin bad++; $display("FAIL prio_hi got=%h exp=1", hi); end
        total++; if (lo !== 32'd2) begin bad++; $display("FAIL prio_lo got=%h exp=2", lo); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_mult_ignored got=%b exp=0", busy); end
    endtask

    task automatic test_mult_with_move();
        multHi = 32'h3; multLo = 32'h4; multCtrl = 1; mtlo = 1; wrData = 32'h99;
        tick();
        multCtrl = 0; mtlo = 0;
        total++; if (lo !== 32'h99) begin bad++; $display("FAIL mult_move_lo got=%h exp=99", lo); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy got=%b exp=1", busy); end
        repeat (31) tick();
        total++; if (lo !== 32'h99) begin bad++; $display("FAIL mult_early got=%h exp=99", lo); end
        tick();
        total++; if (hi !== 32'h3) begin bad++; $display("FAIL mult_hi got=%h exp=3", hi); end
        total++; if (lo !== 32'h4) begin bad++; $display("FAIL mult_lo got=%h exp=4", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_done_busy got=%b exp=0", busy); end
    endtask

    task automatic test_moves();
        mthi = 1; mtlo = 1; wrData = 32'h1234;
        tick();
        mthi = 0; mtlo = 0;
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mt_hi got=%h exp=1234", hi); end
        total++; if (lo !== 32'h1234) begin bad++; $display("FAIL mt_lo got=%h exp=1234", lo); end
        mfhi = 1; #1;
        total++; if (readData !== 32'h1234) begin bad++; $display("FAIL mfhi_data got=%h exp=1234", readData); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mfhi_stall got=%b exp=0", stall); end
        mfhi = 0; mthi = 1; wrData = 32'h55;
        tick();
        mthi = 0; mfhi = 1; mflo = 1; #1;
        total++; if (readData !== 32'h55) begin bad++; $display("FAIL mf_prio got=%h exp=55", readData); end
        mfhi = 0; #1;
        total++; if (readData !== 32'h1234) begin bad++; $display("FAIL mflo_data got=%h exp=1234", readData); end
        mflo = 0; #1;
        total++; if (readData !== 32'h1234) begin bad++; $display("FAIL mf_none got=%h exp=1234", readData); end
    endtask

    task automatic test_reset_mid();
        divHi = 32'hDEAD; divLo = 32'hBEEF; divCtrl = 1;
        tick();
        divCtrl = 0;
        repeat (10) tick();
        mflo = 1; reset = 1; #1;
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rmid_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL rmid_lo got=%h exp=0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%b exp=0", stall); end
        tick(); tick();
        reset = 0; mflo = 0;
        repeat (40) tick();
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rmid_no_capture got=%h exp=0", hi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_div_stall();
        test_div_zero();
        test_div_abort();
        test_priority();
        test_mult_with_move();
        test_moves();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
